// File: rtl/prog_sequencer_if.sv
// Bus bundle between the instruction/control side and the sequencer.
interface prog_sequencer_if #(
    parameter int unsigned D     = 12,
    parameter int unsigned NPROG = 4,
    parameter int unsigned OFFW  = 5,
    parameter int unsigned CW    = 16
);
    localparam int unsigned SW = (NPROG > 1) ? $clog2(NPROG) : 1;

    // start handshake and program selection
    logic            req;
    logic [SW-1:0]   prog_sel;
    // decoded instruction controls
    logic            halt_i;
    logic            absj_en;
    logic            relj_en;
    logic [1:0]      cond_sel;
    logic [D-1:0]    target;
    logic [OFFW-1:0] offset;
    // ALU flag sources
    logic            flag_en;
    logic            zero_i;
    logic            pari_i;
    logic            sc_en;
    logic            sc_clr;
    logic            sc_i;
    // sequencer results
    logic [D-1:0]    prog_ctr;
    logic            run;
    logic            done;
    logic            timeout;
    logic            zeroQ;
    logic            pariQ;
    logic            scQ;
    logic [CW-1:0]   cycle_cnt;

    modport master (
        output req, prog_sel, halt_i, absj_en, relj_en, cond_sel, target, offset,
               flag_en, zero_i, pari_i, sc_en, sc_clr, sc_i,
        input  prog_ctr, run, done, timeout, zeroQ, pariQ, scQ, cycle_cnt
    );

    modport slave (
        input  req, prog_sel, halt_i, absj_en, relj_en, cond_sel, target, offset,
               flag_en, zero_i, pari_i, sc_en, sc_clr, sc_i,
        output prog_ctr, run, done, timeout, zeroQ, pariQ, scQ, cycle_cnt
    );
endinterface

// File: rtl/prog_sequencer.sv
// Fetch/sequencing controller: program slots, conditional jumps, halt,
// registered ALU flags and a run-cycle watchdog behind a 4-phase req/done.
module prog_sequencer #(
    parameter int unsigned D           = 12,
    parameter int unsigned NPROG       = 4,
    parameter int unsigned PROG_STRIDE = 256,
    parameter int unsigned OFFW        = 5,
    parameter int unsigned CW          = 16,
    parameter int unsigned MAX_CYC     = 32'h0000_FFFF
) (
    input  logic             clk,
    input  logic             reset,
    prog_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CW-1:0] CYC_LAST  = CW'(MAX_CYC - 1);
    localparam logic [D-1:0]  STRIDE_M1 = D'(PROG_STRIDE - 1);

    state_t        state_q, state_n;
    logic [D-1:0]  pc_q, pc_n;
    logic [D-1:0]  end_q, end_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          zero_q, zero_n, pari_q, pari_n, sc_q, sc_n;
    logic          to_q, to_n, run_q, run_n, done_q, done_n;
    logic [D-1:0]  start_c;
    logic [D-1:0]  off_c;
    logic          cond_c;

    // Slot base address; out-of-range selections fall back to slot 0.
    always_comb begin
        start_c = '0;
        if (32'(bus.prog_sel) < NPROG) begin
            start_c = D'(32'(bus.prog_sel) * PROG_STRIDE);
        end
    end

    // Branch condition from the flags as registered at the start of the cycle.
    always_comb begin
        off_c  = D'($signed(bus.offset));
        cond_c = 1'b1;
        case (bus.cond_sel)
            2'b00:   cond_c = 1'b1;
            2'b01:   cond_c = zero_q;
            2'b10:   cond_c = ~zero_q;
            default: cond_c = sc_q;
        endcase
    end

    // Next state, program counter, flags and status.
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        end_n   = end_q;
        cnt_n   = cnt_q;
        zero_n  = zero_q;
        pari_n  = pari_q;
        sc_n    = sc_q;
        to_n    = to_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    state_n = S_RUN;
                    pc_n    = start_c;
                    end_n   = start_c + STRIDE_M1;
                    cnt_n   = '0;
                    zero_n  = 1'b0;
                    pari_n  = 1'b0;
                    sc_n    = 1'b0;
                    to_n    = 1'b0;
                end
            end
            S_RUN: begin
                cnt_n = cnt_q + CW'(1);
                if (bus.flag_en) begin
                    zero_n = bus.zero_i;
                    pari_n = bus.pari_i;
                end
                if (bus.sc_clr) begin
                    sc_n = 1'b0;
                end else if (bus.sc_en) begin
                    sc_n = bus.sc_i;
                end
                if (bus.halt_i) begin
                    state_n = S_DONE;
                end else if (cnt_q == CYC_LAST) begin
                    state_n = S_DONE;
                    to_n    = 1'b1;
                end else if (bus.absj_en && cond_c) begin
                    pc_n = bus.target;
                end else if (bus.relj_en && cond_c) begin
                    pc_n = pc_q + off_c;
                end else if (pc_q == end_q) begin
                    state_n = S_DONE;
                end else begin
                    pc_n = pc_q + D'(1);
                end
            end
            S_DONE: begin
                if (!bus.req) begin
                    state_n = S_IDLE;
                    to_n    = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase
        run_n  = (state_n == S_RUN);
        done_n = (state_n == S_DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            pari_q  <= 1'b0;
            sc_q    <= 1'b0;
            to_q    <= 1'b0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            end_q   <= end_n;
            cnt_q   <= cnt_n;
            zero_q  <= zero_n;
            pari_q  <= pari_n;
            sc_q    <= sc_n;
            to_q    <= to_n;
            run_q   <= run_n;
            done_q  <= done_n;
        end
    end

    assign bus.prog_ctr  = pc_q;
    assign bus.run       = run_q;
    assign bus.done      = done_q;
    assign bus.timeout   = to_q;
    assign bus.zeroQ     = zero_q;
    assign bus.pariQ     = pari_q;
    assign bus.scQ       = sc_q;
    assign bus.cycle_cnt = cnt_q;
endmodule
